branch_unit_bp_rv32i: RTL and testbench
=======================================

// Module: branch_unit_bp_rv32i
// PURPOSE
//   Parametrised branch unit for the RV32I core: resolves conditional branches in EX (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   and predicts them in IF via a direct-mapped 2-bit-counter BHT with a tagged target buffer (BTB).
//   Drives the next-PC mux (pc_in), flags mispredicts for pipeline flush, trains tables, counts branches/mispredicts.
// PARAMETERS
//   XLEN      32     datapath/PC width
//   ENTRIES   64     BHT/BTB entries; power of two, >=2; IDXW = log2(ENTRIES)
//   CTR_INIT  2'b01  counter reset value (weakly not-taken)
//   PERF_W    32     width of performance counters
// PORTS
//   clock           in   1         rising-edge clock
//   nreset          in   1         asynchronous active-low reset
//   f_pc            in   XLEN      fetch-stage PC
//   f_pred_taken    out  1         prediction for f_pc (comb.)
//   f_pred_target   out  XLEN      predicted target for f_pc (comb.)
//   e_valid         in   1         EX holds a conditional branch (cu_branch)
//   e_branchtype    in   3         000 BEQ,001 BGE,010 BGEU,011 BLT,100 BLTU,101 BNE; 110/111 illegal
//   e_pc            in   XLEN      PC of EX branch
//   e_pc_plus4      in   XLEN      e_pc+4
//   e_pc_branch     in   XLEN      e_pc+imm from ALU
//   e_rs1, e_rs2    in   XLEN      operand values
//   e_pred_taken    in   1         prediction carried from IF with this branch
//   e_pred_target   in   XLEN      predicted target carried from IF
//   mispredict      out  1         EX branch mispredicted; flush IF/ID (comb.)
//   pc_in           out  XLEN      next PC to PC register (comb.)
//   perf_branches   out  PERF_W    resolved legal branches
//   perf_mispred    out  PERF_W    mispredicted legal branches
// BEHAVIOUR
//   Lookup: idx=f_pc[IDXW+1:2], tag=f_pc[XLEN-1:IDXW+2]. hit=valid[idx]&&tag match.
//     f_pred_taken=hit&&ctr[idx][1]; f_pred_target=hit?tgt[idx]:f_pc+4.
//   Resolve (e_valid, legal type): taken per type; BGE/BLT signed, BGEU/BLTU unsigned, BEQ/BNE equality.
//     mispredict=(taken!=e_pred_taken)||(taken&&e_pred_target!=e_pc_branch).
//   pc_in: mispredict ? (taken?e_pc_branch:e_pc_plus4) : f_pred_target. Comb.; EX redirect overrides IF prediction.
//   e_valid=0 or illegal type: taken=0, mispredict=e_valid&&e_pred_taken (recover to e_pc_plus4);
//     no table update, no perf count.
//   Update at clock edge after resolve (legal, e_valid), index/tag from e_pc:
//     tag hit: ctr +1 if taken, -1 if not, saturating 00..11; if taken, tgt<=e_pc_branch.
//     tag miss & taken: allocate valid=1, tag, tgt=e_pc_branch, ctr=2'b10. miss & not-taken: no change.
//   Same-cycle lookup and update of one index: lookup sees pre-update contents (update visible next cycle).
//   Perf: perf_branches+1 per legal resolve; perf_mispred+1 if also mispredict; both wrap mod 2^PERF_W.
//   Reset (nreset=0, any time, async): all valid=0, all ctr=CTR_INIT, tgt/tag=0, perf=0.
//     Outputs during reset: f_pred_taken=0, f_pred_target=f_pc+4, pc_in per comb. rules on inputs.
//     Reset mid-update: write discarded; tables come out of reset fully cleared.
//   Latency: prediction/resolution 0 cycles (comb.); training 1 cycle.
// TESTING
//   1 Reset, f_pc=0x100 -> f_pred_taken=0, f_pred_target=0x104, perf=0.
//   2 BEQ e_pc=0x100, rs1=rs2=5, pred=0, pc_branch=0x80 -> mispredict=1, pc_in=0x80; next cycle f_pc=0x100
//     -> pred_taken=1, target=0x80, perf_branches=1, perf_mispred=1.
//   3 Same branch taken x3 then not-taken x1 -> ctr 10->11->11 (sat.), then 10; still predicts taken; no mispredict
//     when pred=1/target=0x80 matches.
//   4 BLT rs1=0xFFFFFFFF rs2=1 -> taken; BLTU same operands -> not-taken; BGE/BGEU complement.
//   5 Alias: ENTRIES=64, train 0x100 taken, then lookup 0x200 (same idx, diff tag) -> pred 0, target 0x204;
//     0x200 taken -> replaces entry, ctr=10.
//   6 Illegal type 3'b111 with pred=1 -> mispredict=1, pc_in=e_pc_plus4, tables/perf unchanged;
//     nreset pulse mid-stream -> all entries invalid, perf=0 immediately.

Source files
------------

// File: rtl/branch_unit_bp_rv32i_if.sv
// Fetch-prediction and execute-resolution signals shared by the branch unit and the core.
// The slave modport is the branch unit's view; the master modport is the pipeline's view.
interface branch_unit_bp_rv32i_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PERF_W = 32
);
  logic [XLEN-1:0]   f_pc;
  logic              f_pred_taken;
  logic [XLEN-1:0]   f_pred_target;
  logic              e_valid;
  logic [2:0]        e_branchtype;
  logic [XLEN-1:0]   e_pc;
  logic [XLEN-1:0]   e_pc_plus4;
  logic [XLEN-1:0]   e_pc_branch;
  logic [XLEN-1:0]   e_rs1;
  logic [XLEN-1:0]   e_rs2;
  logic              e_pred_taken;
  logic [XLEN-1:0]   e_pred_target;
  logic              mispredict;
  logic [XLEN-1:0]   pc_in;
  logic [PERF_W-1:0] perf_branches;
  logic [PERF_W-1:0] perf_mispred;

  modport slave (
    input  f_pc, e_valid, e_branchtype, e_pc, e_pc_plus4, e_pc_branch, e_rs1, e_rs2,
           e_pred_taken, e_pred_target,
    output f_pred_taken, f_pred_target, mispredict, pc_in, perf_branches, perf_mispred
  );

  modport master (
    output f_pc, e_valid, e_branchtype, e_pc, e_pc_plus4, e_pc_branch, e_rs1, e_rs2,
           e_pred_taken, e_pred_target,
    input  f_pred_taken, f_pred_target, mispredict, pc_in, perf_branches, perf_mispred
  );
endinterface

// File: rtl/branch_unit_bp_rv32i.sv
// RV32I branch unit: EX-stage conditional branch resolution plus an IF-stage
// direct-mapped 2-bit BHT with tagged BTB, next-PC selection and perf counters.
module branch_unit_bp_rv32i #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 64,
  parameter logic [1:0]  CTR_INIT = 2'b01,
  parameter int unsigned PERF_W   = 32
) (
  input logic                   clock,
  input logic                   nreset,
  branch_unit_bp_rv32i_if.slave bus
);

  localparam int unsigned IDXW = $clog2(ENTRIES);
  localparam int unsigned TAGW = XLEN - IDXW - 2;
  localparam logic [XLEN-1:0] PcInc = XLEN'(4);

  localparam logic [2:0] BrBeq  = 3'b000;
  localparam logic [2:0] BrBge  = 3'b001;
  localparam logic [2:0] BrBgeu = 3'b010;
  localparam logic [2:0] BrBlt  = 3'b011;
  localparam logic [2:0] BrBltu = 3'b100;
  localparam logic [2:0] BrBne  = 3'b101;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         ctr_q [ENTRIES];
  logic [1:0]         ctr_d [ENTRIES];
  logic [TAGW-1:0]    tag_q [ENTRIES];
  logic [TAGW-1:0]    tag_d [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic [XLEN-1:0]    tgt_d [ENTRIES];
  logic [PERF_W-1:0]  perf_branches_q, perf_branches_d;
  logic [PERF_W-1:0]  perf_mispred_q, perf_mispred_d;

  // Fetch-side lookup
  logic [IDXW-1:0] f_idx;
  logic [TAGW-1:0] f_tag;
  logic            f_hit;

  assign f_idx = bus.f_pc[IDXW+1:2];
  assign f_tag = bus.f_pc[XLEN-1:IDXW+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign bus.f_pred_taken  = f_hit && ctr_q[f_idx][1];
  assign bus.f_pred_target = f_hit ? tgt_q[f_idx] : bus.f_pc + PcInc;

  // Execute-side resolution
  logic legal, cond, resolve, taken, mispredict;
  logic eq, lt_s, lt_u;

  assign eq   = bus.e_rs1 == bus.e_rs2;
  assign lt_s = $signed(bus.e_rs1) < $signed(bus.e_rs2);
  assign lt_u = bus.e_rs1 < bus.e_rs2;

  always_comb begin
    legal = 1'b1;
    cond  = 1'b0;
    case (bus.e_branchtype)
      BrBeq:   cond = eq;
      BrBge:   cond = !lt_s;
      BrBgeu:  cond = !lt_u;
      BrBlt:   cond = lt_s;
      BrBltu:  cond = lt_u;
      BrBne:   cond = !eq;
      default: legal = 1'b0;
    endcase
  end

  assign resolve = bus.e_valid && legal;
  assign taken   = resolve && cond;

  // Illegal or idle slots only recover a stale taken prediction back to the fall-through path.
  always_comb begin
    if (resolve) begin
      mispredict = (taken != bus.e_pred_taken) ||
                   (taken && (bus.e_pred_target != bus.e_pc_branch));
    end else begin
      mispredict = bus.e_valid && bus.e_pred_taken;
    end
  end

  assign bus.mispredict = mispredict;
  assign bus.pc_in      = mispredict ? (taken ? bus.e_pc_branch : bus.e_pc_plus4)
                                     : bus.f_pred_target;

  // Table training
  logic [IDXW-1:0] u_idx;
  logic [TAGW-1:0] u_tag;
  logic            u_hit;

  assign u_idx = bus.e_pc[IDXW+1:2];
  assign u_tag = bus.e_pc[XLEN-1:IDXW+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (resolve) begin
      if (u_hit) begin
        if (taken) begin
          if (ctr_q[u_idx] != 2'b11) ctr_d[u_idx] = ctr_q[u_idx] + 2'b01;
          tgt_d[u_idx] = bus.e_pc_branch;
        end else if (ctr_q[u_idx] != 2'b00) begin
          ctr_d[u_idx] = ctr_q[u_idx] - 2'b01;
        end
      end else if (taken) begin
        valid_d[u_idx] = 1'b1;
        tag_d[u_idx]   = u_tag;
        tgt_d[u_idx]   = bus.e_pc_branch;
        ctr_d[u_idx]   = 2'b10;
      end
    end
  end

  assign perf_branches_d = perf_branches_q + {{(PERF_W-1){1'b0}}, resolve};
  assign perf_mispred_d  = perf_mispred_q + {{(PERF_W-1){1'b0}}, resolve && mispredict};

  assign bus.perf_branches = perf_branches_q;
  assign bus.perf_mispred  = perf_mispred_q;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      valid_q         <= '0;
      perf_branches_q <= '0;
      perf_mispred_q  <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ctr_q[i] <= CTR_INIT;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      valid_q         <= valid_d;
      ctr_q           <= ctr_d;
      tag_q           <= tag_d;
      tgt_q           <= tgt_d;
      perf_branches_q <= perf_branches_d;
      perf_mispred_q  <= perf_mispred_d;
    end
  end

  // PC byte-offset bits never select table state.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bus.f_pc[1:0], bus.e_pc[1:0]};

endmodule

// File: tb/tb_branch_unit_bp_rv32i.sv
// Scoreboard bench for branch_unit_bp_rv32i: a behavioural BHT/BTB model predicts each
// cycle's combinational outputs; expectations are queued on drive and popped on sampling.
module tb_branch_unit_bp_rv32i;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRIES = 64;
  localparam int unsigned IDXW    = 6;
  localparam int unsigned PERF_W  = 32;

  typedef struct {
    logic        mp;
    logic [31:0] pcin;
    logic        ptk;
    logic [31:0] ptg;
  } exp_t;

  logic clock = 1'b0;
  logic nreset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sbq[$];

  bit          m_valid [ENTRIES];
  bit [1:0]    m_ctr   [ENTRIES];
  bit [23:0]   m_tag   [ENTRIES];
  bit [31:0]   m_tgt   [ENTRIES];
  int unsigned m_br, m_mp;

  branch_unit_bp_rv32i_if #(.XLEN(XLEN), .PERF_W(PERF_W)) bus ();

  branch_unit_bp_rv32i #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_INIT(2'b01), .PERF_W(PERF_W)
  ) dut (
    .clock(clock),
    .nreset(nreset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  function automatic int unsigned idx_of(bit [31:0] pc);
    return (pc >> 2) % ENTRIES;
  endfunction

  function automatic bit [23:0] tag_of(bit [31:0] pc);
    return 24'(pc >> (IDXW + 2));
  endfunction

  function automatic bit m_cond(bit [2:0] ty, bit [31:0] a, bit [31:0] b);
    case (ty)
      3'd0:    return a == b;
      3'd1:    return $signed(a) >= $signed(b);
      3'd2:    return a >= b;
      3'd3:    return $signed(a) < $signed(b);
      3'd4:    return a < b;
      3'd5:    return a != b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < int'(ENTRIES); i++) begin
      m_valid[i] = 0; m_ctr[i] = 2'b01; m_tag[i] = 0; m_tgt[i] = 0;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  task automatic m_pred(input bit [31:0] pc, output bit tk, output bit [31:0] tg);
    int unsigned i = idx_of(pc);
    bit hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    tk = hit && m_ctr[i][1];
    tg = hit ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic m_train(input bit [31:0] pc, input bit tk, input bit [31:0] tg);
    int unsigned i = idx_of(pc);
    if (m_valid[i] && (m_tag[i] == tag_of(pc))) begin
      if (tk) begin
        if (m_ctr[i] != 2'b11) m_ctr[i] = m_ctr[i] + 2'b01;
        m_tgt[i] = tg;
      end else if (m_ctr[i] != 2'b00) begin
        m_ctr[i] = m_ctr[i] - 2'b01;
      end
    end else if (tk) begin
      m_valid[i] = 1; m_tag[i] = tag_of(pc); m_tgt[i] = tg; m_ctr[i] = 2'b10;
    end
  endtask

  // Drives one cycle at the falling edge and queues the expected combinational outputs.
  task automatic drive(input bit v, input bit [2:0] ty, input bit [31:0] fpc, input bit [31:0] epc,
                       input bit [31:0] a, input bit [31:0] b, input bit [31:0] pcb,
                       input bit ptk, input bit [31:0] ptg);
    exp_t e;
    bit ftk, tk, mp, legal;
    bit [31:0] ftg;
    @(negedge clock);
    bus.f_pc = fpc; bus.e_valid = v; bus.e_branchtype = ty; bus.e_pc = epc;
    bus.e_pc_plus4 = epc + 32'd4; bus.e_pc_branch = pcb; bus.e_rs1 = a; bus.e_rs2 = b;
    bus.e_pred_taken = ptk; bus.e_pred_target = ptg;
    m_pred(fpc, ftk, ftg);
    legal = ty <= 3'd5;
    tk = v && legal && m_cond(ty, a, b);
    if (v && legal) mp = (tk != ptk) || (tk && (ptg != pcb));
    else            mp = v && ptk;
    e.mp = mp; e.pcin = mp ? (tk ? pcb : epc + 32'd4) : ftg; e.ptk = ftk; e.ptg = ftg;
    sbq.push_back(e);
    if (v && legal) begin
      m_br++;
      if (mp) m_mp++;
      m_train(epc, tk, pcb);
    end
    #1;
  endtask

  task automatic idle(input bit [31:0] fpc);
    drive(0, 3'd0, fpc, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  task automatic test_reset();
    exp_t e;
    nreset = 1'b0;
    bus.f_pc = 32'h100; bus.e_valid = 0; bus.e_branchtype = 0; bus.e_pc = 0;
    bus.e_pc_plus4 = 0; bus.e_pc_branch = 0; bus.e_rs1 = 0; bus.e_rs2 = 0;
    bus.e_pred_taken = 0; bus.e_pred_target = 0;
    m_reset();
    #3;
    n_checks++;
    if (bus.f_pred_taken !== 1'b0 || bus.f_pred_target !== 32'h104) begin
      n_fail++;
      $display("FAIL reset_pred: got %b/%h want 0/00000104", bus.f_pred_taken, bus.f_pred_target);
    end
    n_checks++;
    if (bus.perf_branches !== 32'd0 || bus.perf_mispred !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_perf: got %0d/%0d want 0/0", bus.perf_branches, bus.perf_mispred);
    end
    @(negedge clock);
    nreset = 1'b1;
    idle(32'h100);
    e = sbq.pop_front(); n_checks++;
    if ({bus.mispredict, bus.pc_in, bus.f_pred_taken, bus.f_pred_target} !== {e.mp, e.pcin, e.ptk, e.ptg}) begin
      n_fail++;
      $display("FAIL reset_idle: got mp=%b pc_in=%h pt=%b ptg=%h want mp=%b pc_in=%h pt=%b ptg=%h",
               bus.mispredict, bus.pc_in, bus.f_pred_taken, bus.f_pred_target, e.mp, e.pcin, e.ptk, e.ptg);
    end
  endtask

  task automatic test_beq_train();
    exp_t e;
    drive(1, 3'd0, 32'h100, 32'h100, 32'd5, 32'd5, 32'h80, 0, 32'h104);
    e = sbq.pop_front(); n_checks++;
    if ({bus.mispredict, bus.pc_in, bus.f_pred_taken, bus.f_pred_target} !== {e.mp, e.pcin, e.ptk, e.ptg}) begin
      n_fail++;
      $display("FAIL beq_resolve: got mp=%b pc_in=%h pt=%b ptg=%h want mp=%b pc_in=%h pt=%b ptg=%h",
               bus.mispredict, bus.pc_in, bus.f_pred_taken, bus.f_pred_target, e.mp, e.pcin, e.ptk, e.ptg);
    end
    n_checks++;
    if (bus.mispredict !== 1'b1 || bus.pc_in !== 32'h80) begin
      n_fail++;
      $display("FAIL beq_redirect: got mp=%b pc_in=%h want 1/00000080", bus.mispredict, bus.pc_in);
    end
    idle(32'h100);
    e = sbq.pop_front(); n_checks++;
    if ({bus.mispredict, bus.pc_in, bus.f_pred_taken, bus.f_pred_target} !== {e.mp, e.pcin, e.ptk, e.ptg}) begin
      n_fail++;
      $display("FAIL beq_lookup: got mp=%b pc_in=%h pt=%b ptg=%h want mp=%b pc_in=%h pt=%b ptg=%h",
               bus.mispredict, bus.pc_in, bus.f_pred_taken, bus.f_pred_target, e.mp, e.pcin, e.ptk, e.ptg);
    end
    n_checks++;
    if (bus.f_pred_taken !== 1'b1 || bus.f_pred_target !== 32'h80 ||
        bus.perf_branches !== 32'd1 || bus.perf_mispred !== 32'd1) begin
      n_fail++;
      $display("FAIL beq_trained: got pt=%b ptg=%h br=%0d mp=%0d want 1/00000080/1/1",
               bus.f_pred_taken, bus.f_pred_target, bus.perf_branches, bus.perf_mispred);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    // Three taken, two not-taken, with an idle lookup after each step.
    for (int i = 0; i < 5; i++) begin
      drive(1, 3'd0, 32'h100, 32'h100, 32'd5, (i < 3) ? 32'd5 : 32'd6, 32'h80, 1, 32'h80);
      e = sbq.pop_front(); n_checks++;
      if ({bus.mispredict, bus.pc_in, bus.f_pred_taken, bus.f_pred_target} !== {e.mp, e.pcin, e.ptk, e.ptg}) begin
        n_fail++;
        $display("FAIL sat_resolve[%0d]: got mp=%b pc_in=%h pt=%b ptg=%h want mp=%b pc_in=%h pt=%b ptg=%h",
                 i, bus.mispredict, bus.pc_in, bus.f_pred_taken, bus.f_pred_target, e.mp, e.pcin, e.ptk, e.ptg);
      end
      idle(32'h100);
      e = sbq.pop_front(); n_checks++;
      if ({bus.mispredict, bus.pc_in, bus.f_pred_taken, bus.f_pred_target} !== {e.mp, e.pcin, e.ptk, e.ptg}) begin
        n_fail++;
        $display("FAIL sat_lookup[%0d]: got mp=%b pc_in=%h pt=%b ptg=%h want mp=%b pc_in=%h pt=%b ptg=%h",
                 i, bus.mispredict, bus.pc_in, bus.f_pred_taken, bus.f_pred_target, e.mp, e.pcin, e.ptk, e.ptg);
      end
    end
    n_checks++;
    if (bus.perf_branches !== m_br || bus.perf_mispred !== m_mp) begin
      n_fail++;
      $display("FAIL sat_perf: got %0d/%0d want %0d/%0d", bus.perf_branches, bus.perf_mispred, m_br, m_mp);
    end
  endtask

  task automatic test_signed_unsigned();
    exp_t e;
    bit [2:0] tys [4] = '{3'd3, 3'd4, 3'd1, 3'd2};
    bit       want[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(1, tys[i], 32'h500, 32'h400 + 32'(4 * i), 32'hFFFF_FFFF, 32'd1, 32'h1000 + 32'(4 * i), 0, 32'h0);
      e = sbq.pop_front(); n_checks++;
      if ({bus.mispredict, bus.pc_in, bus.f_pred_taken, bus.f_pred_target} !== {e.mp, e.pcin, e.ptk, e.ptg}) begin
        n_fail++;
        $display("FAIL cmp_resolve[%0d]: got mp=%b pc_in=%h pt=%b ptg=%h want mp=%b pc_in=%h pt=%b ptg=%h",
                 i, bus.mispredict, bus.pc_in, bus.f_pred_taken, bus.f_pred_target, e.mp, e.pcin, e.ptk, e.ptg);
      end
      n_checks++;
      if (bus.mispredict !== want[i]) begin
        n_fail++;
        $display("FAIL cmp_taken[%0d]: got %b want %b", i, bus.mispredict, want[i]);
      end
    end
  endtask

  task automatic test_alias();
    exp_t e;
    bit [31:0] fpcs [4] = '{32'h200, 32'h200, 32'h200, 32'h100};
    bit        vs   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit        wtk  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    bit [31:0] wtg  [4] = '{32'h204, 32'h204, 32'h300, 32'h104};
    for (int i = 0; i < 4; i++) begin
      drive(vs[i], 3'd0, fpcs[i], 32'h200, 32'd7, 32'd7, 32'h300, 0, 32'h0);
      e = sbq.pop_front(); n_checks++;
      if ({bus.mispredict, bus.pc_in, bus.f_pred_taken, bus.f_pred_target} !== {e.mp, e.pcin, e.ptk, e.ptg}) begin
        n_fail++;
        $display("FAIL alias[%0d]: got mp=%b pc_in=%h pt=%b ptg=%h want mp=%b pc_in=%h pt=%b ptg=%h",
                 i, bus.mispredict, bus.pc_in, bus.f_pred_taken, bus.f_pred_target, e.mp, e.pcin, e.ptk, e.ptg);
      end
      n_checks++;
      if (bus.f_pred_taken !== wtk[i] || bus.f_pred_target !== wtg[i]) begin
        n_fail++;
        $display("FAIL alias_pred[%0d]: got %b/%h want %b/%h", i, bus.f_pred_taken, bus.f_pred_target, wtk[i], wtg[i]);
      end
    end
  endtask

  task automatic test_illegal_reset();
    exp_t e;
    bit [2:0]  tys [4] = '{3'd7, 3'd6, 3'd0, 3'd0};
    bit        vs  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    bit        pts [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit [31:0] fps [4] = '{32'h200, 32'h200, 32'h200, 32'h600};
    int unsigned br0 = m_br;
    int unsigned mp0 = m_mp;
    for (int i = 0; i < 4; i++) begin
      drive(vs[i], tys[i], fps[i], 32'h600, 32'd3, 32'd3, 32'h700, pts[i], 32'h700);
      e = sbq.pop_front(); n_checks++;
      if ({bus.mispredict, bus.pc_in, bus.f_pred_taken, bus.f_pred_target} !== {e.mp, e.pcin, e.ptk, e.ptg}) begin
        n_fail++;
        $display("FAIL illegal[%0d]: got mp=%b pc_in=%h pt=%b ptg=%h want mp=%b pc_in=%h pt=%b ptg=%h",
                 i, bus.mispredict, bus.pc_in, bus.f_pred_taken, bus.f_pred_target, e.mp, e.pcin, e.ptk, e.ptg);
      end
    end
    n_checks++;
    if (bus.perf_branches !== br0 || bus.perf_mispred !== mp0 || bus.f_pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_nochange: got br=%0d mp=%0d pt=%b want %0d/%0d/0",
               bus.perf_branches, bus.perf_mispred, bus.f_pred_taken, br0, mp0);
    end
    // Assert reset mid-cycle with a taken branch pending and hold it across an edge.
    @(negedge clock);
    bus.f_pc = 32'h200; bus.e_valid = 1; bus.e_branchtype = 3'd0; bus.e_pc = 32'h200;
    bus.e_pc_plus4 = 32'h204; bus.e_pc_branch = 32'h900; bus.e_rs1 = 1; bus.e_rs2 = 1;
    bus.e_pred_taken = 0; bus.e_pred_target = 0;
    #2 nreset = 1'b0;
    m_reset();
    #1;
    n_checks++;
    if (bus.f_pred_taken !== 1'b0 || bus.f_pred_target !== 32'h204 ||
        bus.perf_branches !== 32'd0 || bus.perf_mispred !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_now: got pt=%b ptg=%h br=%0d mp=%0d want 0/00000204/0/0",
               bus.f_pred_taken, bus.f_pred_target, bus.perf_branches, bus.perf_mispred);
    end
    n_checks++;
    if (bus.mispredict !== 1'b1 || bus.pc_in !== 32'h900) begin
      n_fail++;
      $display("FAIL midreset_comb: got mp=%b pc_in=%h want 1/00000900", bus.mispredict, bus.pc_in);
    end
    @(negedge clock);
    bus.e_valid = 0;
    nreset = 1'b1;
    idle(32'h200);
    e = sbq.pop_front(); n_checks++;
    if ({bus.mispredict, bus.pc_in, bus.f_pred_taken, bus.f_pred_target} !== {e.mp, e.pcin, e.ptk, e.ptg}
        || bus.perf_branches !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_after: got mp=%b pc_in=%h pt=%b ptg=%h br=%0d want mp=%b pc_in=%h pt=%b ptg=%h br=0",
               bus.mispredict, bus.pc_in, bus.f_pred_taken, bus.f_pred_target, bus.perf_branches,
               e.mp, e.pcin, e.ptk, e.ptg);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit [31:0] ops [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd5};
    for (int i = 0; i < 300; i++) begin
      bit [31:0] fpc, epc, ptg, pcb;
      bit ptk;
      // Four tags over four indices, so hits and aliasing both occur.
      fpc = {22'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 2'b00} << 2;
      epc = {22'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 2'b00} << 2;
      pcb = 32'h4000 + 32'($urandom_range(0, 3) * 16);
      m_pred(epc, ptk, ptg);
      if ($urandom_range(0, 3) == 0) begin
        ptk = 1'($urandom_range(0, 1));
        ptg = 32'h4000 + 32'($urandom_range(0, 3) * 16);
      end
      drive(1'($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)), fpc, epc,
            ops[$urandom_range(0, 4)], ops[$urandom_range(0, 4)], pcb, ptk, ptg);
      e = sbq.pop_front(); n_checks++;
      if ({bus.mispredict, bus.pc_in, bus.f_pred_taken, bus.f_pred_target} !== {e.mp, e.pcin, e.ptk, e.ptg}) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got mp=%b pc_in=%h pt=%b ptg=%h want mp=%b pc_in=%h pt=%b ptg=%h",
                 i, bus.mispredict, bus.pc_in, bus.f_pred_taken, bus.f_pred_target, e.mp, e.pcin, e.ptk, e.ptg);
      end
    end
    idle(32'h0);
    void'(sbq.pop_front());
    n_checks++;
    if (bus.perf_branches !== m_br || bus.perf_mispred !== m_mp) begin
      n_fail++;
      $display("FAIL b2b_perf: got %0d/%0d want %0d/%0d", bus.perf_branches, bus.perf_mispred, m_br, m_mp);
    end
  endtask

  initial begin
    test_reset();
    test_beq_train();
    test_saturation();
    test_signed_unsigned();
    test_alias();
    test_illegal_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
